// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - core data port and data memory signals of the load-store unit
interface riscv_lsu_if;
  // core side
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_err_o;
  // memory side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  // LSU view: serves the core, masters the memory
  modport master (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, core_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  // environment view: core plus memory
  modport slave (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, core_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load-store unit between the core data port and data memory
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  riscv_lsu_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             we_q;
  logic [2:0]       size_q;
  logic [31:0]      addr_q;
  logic [31:0]      wd_q;
  logic             err_q, err_d;
  logic [31:0]      rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             size_legal;
  logic             misaligned;
  logic             busy;
  logic [3:0]       be_w;
  logic [31:0]      wd_w;
  logic [31:0]      rd_shift;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      rd_fmt;

  // decode legality of the access currently offered by the core
  always_comb begin
    size_legal = 1'b0;
    misaligned = 1'b0;
    case (bus.core_size_i)
      3'd0, 3'd1, 3'd2: size_legal = 1'b1;
      3'd4, 3'd5:       size_legal = !bus.core_we_i;
      default:          size_legal = 1'b0;
    endcase
    if (bus.core_size_i[1:0] == 2'd1) misaligned = bus.core_addr_i[0];
    if (bus.core_size_i[1:0] == 2'd2) misaligned = (bus.core_addr_i[1:0] != 2'b00);
  end

  // byte lanes, replicated store data and formatted load data from the latched access
  always_comb begin
    be_w = 4'b1111;
    wd_w = wd_q;
    case (size_q[1:0])
      2'd0: begin
        be_w = 4'b0001 << addr_q[1:0];
        wd_w = {4{wd_q[7:0]}};
      end
      2'd1: begin
        be_w = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_w = {2{wd_q[15:0]}};
      end
      default: ;
    endcase
    rd_shift = bus.mem_rd_i >> {addr_q[1:0], 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = addr_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    case (size_q)
      3'd0:    rd_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    rd_fmt = {24'b0, rd_byte};
      3'd1:    rd_fmt = {{16{rd_half[15]}}, rd_half};
      3'd5:    rd_fmt = {16'b0, rd_half};
      default: rd_fmt = bus.mem_rd_i;
    endcase
  end

  // state, error flag, load result and timeout counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // capture the core access when it is accepted in IDLE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q   <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wd_q   <= '0;
    end else if (state_q == IDLE && bus.core_req_i) begin
      we_q   <= bus.core_we_i;
      size_q <= bus.core_size_i;
      addr_q <= bus.core_addr_i;
      wd_q   <= bus.core_wd_i;
    end
  end

  // next-state logic and core handshake
  always_comb begin
    state_d          = state_q;
    err_d            = err_q;
    rd_d             = rd_q;
    cnt_d            = cnt_q;
    busy             = 1'b0;
    bus.core_stall_o = 1'b0;
    bus.core_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.core_stall_o = bus.core_req_i;
        if (bus.core_req_i) begin
          cnt_d = '0;
          if (!size_legal || misaligned) begin
            // rejected without touching memory
            err_d   = 1'b1;
            state_d = DONE;
            if (!bus.core_we_i) rd_d = '0;
          end else begin
            err_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        busy             = 1'b1;
        bus.core_stall_o = 1'b1;
        if (bus.mem_ready_i) begin
          if (!we_q) rd_d = rd_fmt;
          state_d = DONE;
        end else if (TIMEOUT_CYCLES != 0 && (cnt_q + CNT_W'(1)) == TMO) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rd_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // retire cycle; a request seen here belongs to the retiring instruction
        bus.core_err_o = err_q;
        err_d          = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.core_rd_o  = rd_q;
  assign bus.mem_req_o  = busy;
  assign bus.mem_we_o   = busy & we_q;
  assign bus.mem_be_o   = busy ? be_w : 4'b0000;
  assign bus.mem_addr_o = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wd_o   = busy ? wd_w : 32'h0;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - randomized self-checking bench for riscv_lsu
module tb_riscv_lsu;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] m_rd = 32'h0;

  riscv_lsu_if bus ();

  riscv_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // one core access, started just after a rising edge; returns just after the retire edge
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input int delay, input logic [31:0] rdata);
    int          nbytes;
    bit          legal, early, tmo_hit, done;
    int          busy_n, req_n, stall_n;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, sh;
    legal  = we ? (size <= 2) : (size <= 2 || size == 4 || size == 5);
    nbytes = (size % 4 == 0) ? 1 : (size % 4 == 1) ? 2 : 4;
    early  = !legal || (addr % nbytes != 0);
    e_be   = 4'(((1 << nbytes) - 1) << (addr % 4));
    e_wd   = (nbytes == 1) ? wd[7:0] * 32'h01010101 :
             (nbytes == 2) ? wd[15:0] * 32'h00010001 : wd;
    tmo_hit = !early && delay >= TMO;
    busy_n  = early ? 0 : (tmo_hit ? TMO : delay + 1);
    if (nbytes == 1) begin
      sh   = (rdata >> ((addr % 4) * 8)) & 32'hFF;
      e_rd = (size == 0 && sh[7]) ? (sh | 32'hFFFFFF00) : sh;
    end else if (nbytes == 2) begin
      sh   = (rdata >> ((addr & 2) * 8)) & 32'hFFFF;
      e_rd = (size == 1 && sh[15]) ? (sh | 32'hFFFF0000) : sh;
    end else begin
      e_rd = rdata;
    end
    if (!we) m_rd = (early || tmo_hit) ? 32'h0 : e_rd;

    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    req_n = 0;
    stall_n = 0;
    done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus.mem_req_o) begin
        req_n++;
        if (early) check("unexpected_mem_req", 32'(bus.mem_req_o), 32'h0);
        else begin
          check("mem_be", 32'(bus.mem_be_o), 32'(e_be));
          check("mem_we", 32'(bus.mem_we_o), 32'(we));
          check("mem_addr", bus.mem_addr_o, addr & 32'hFFFFFFFC);
          check("mem_wd", bus.mem_wd_o, e_wd);
        end
        bus.mem_ready_i = (req_n - 1 == delay);
        bus.mem_rd_i    = (req_n - 1 == delay) ? rdata : $urandom;
      end else begin
        bus.mem_ready_i = 1'($urandom);
        bus.mem_rd_i    = $urandom;
      end
      if (bus.core_stall_o) begin
        stall_n++;
        check("err_while_stalled", 32'(bus.core_err_o), 32'h0);
      end else begin
        done = 1;
        check("err", 32'(bus.core_err_o), 32'(early || tmo_hit));
        check("rd", bus.core_rd_o, m_rd);
        check("stall_cycles", 32'(stall_n), 32'(busy_n + 1));
        check("req_cycles", 32'(req_n), 32'(busy_n));
        check("be_idle", 32'(bus.mem_be_o), 32'h0);
      end
    end
    if (!done) check("retire_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
  endtask

  initial begin
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'h0;
    bus.core_wd_i   = 32'h0;
    bus.mem_rd_i    = 32'h0;
    bus.mem_ready_i = 1'b0;
    #12;
    check("rst_stall", 32'(bus.core_stall_o), 32'h0);
    check("rst_err", 32'(bus.core_err_o), 32'h0);
    check("rst_rd", bus.core_rd_o, 32'h0);
    check("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
    check("rst_mem_be", 32'(bus.mem_be_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_access(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    check("lw_rd_const", bus.core_rd_o, 32'hDEADBEEF);
    run_access(1'b0, 3'd0, 32'h13, 32'h0, 1, 32'h80FF0000);
    check("lb_rd_const", bus.core_rd_o, 32'hFFFFFF80);
    run_access(1'b0, 3'd4, 32'h13, 32'h0, 2, 32'h80FF0000);
    check("lbu_rd_const", bus.core_rd_o, 32'h00000080);
    run_access(1'b1, 3'd1, 32'h22, 32'h1234ABCD, 0, 32'h0);
    check("sh_rd_kept", bus.core_rd_o, 32'h00000080);
    run_access(1'b1, 3'd2, 32'h05, 32'h0, 0, 32'h0);
    run_access(1'b0, 3'd2, 32'h40, 32'h0, 99, 32'h12345678);
    check("timeout_rd_const", bus.core_rd_o, 32'h0);

    // reset in the middle of a BUSY phase
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h80;
    @(posedge clk);
    @(negedge clk);
    check("busy_before_rst", 32'(bus.mem_req_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req_o), 32'h0);
    check("rst_mid_err", 32'(bus.core_err_o), 32'h0);
    check("rst_mid_rd", bus.core_rd_o, 32'h0);
    m_rd = 32'h0;
    bus.core_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_access(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hCAFEF00D);
    run_access(1'b1, 3'd2, 32'h104, 32'h55AA33CC, 1, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      logic        w;
      w  = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
      if (sz == 3'd3) sz = 3'd2;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (sz[1:0] == 2'd1) ? {a[1], 1'b0} : 2'b00;
      run_access(w, sz, a, $urandom, $urandom_range(0, TMO + 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
